fifo_ctrl: RTL and testbench

//   Central sequencing controller for the single-clock FIFO memory.
//   - Owns the write and read pointers, occupancy count, full/empty flags and sticky error flags.
//   - Drives address and strobe inputs of the FIFO storage array.
//   - Sits between the producer/consumer enables and the memory.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr_counter.sv | 29 ++
 rtl/fifo_ctrl.sv | 147 ++++++++++++++
 tb/tb_fifo_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller: FSM state encoding and depth helper.
package fifo_pkg;

  localparam int DEFAULT_BUFFER_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_t;

  function automatic int depthOf(input int bufferWidth);
    return 1 << bufferWidth;
  endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Enable-gated wrap-around pointer counter with async reset and sync clear.
module fifo_ptr_counter
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_BUFFER_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Wrap from DEPTH-1 back to 0 falls out of the natural binary overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for the single-clock FIFO: pointers, count, flags, sticky errors.
// Almost-full/almost-empty flags are built only when FIFO_ALMOST_FLAGS_EN is defined.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_THRESHOLD = 6,
  parameter int AE_THRESHOLD = 2
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    write_Enable,
  input  logic                    read_Enable,
  output logic                    write_Fire,
  output logic                    read_Fire,
  output logic [BUFFER_WIDTH-1:0] write_Pointer,
  output logic [BUFFER_WIDTH-1:0] read_Pointer,
  output logic [BUFFER_WIDTH:0]   fifo_Count,
  output logic                    sig_Full,
  output logic                    sig_Empty,
  output logic                    sig_Overflow,
  output logic                    sig_Underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                    sig_Almost_Full,
  output logic                    sig_Almost_Empty
`endif
);

  localparam int DEPTH = depthOf(BUFFER_WIDTH);
  localparam int CW    = BUFFER_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  fifo_state_t   r_state;
  fifo_state_t   w_stateNext;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic          r_overflow;
  logic          r_underflow;
  logic          w_writeFire;
  logic          w_readFire;

  assign w_writeFire   = write_Enable & ~sig_Full  & ~flush;
  assign w_readFire    = read_Enable  & ~sig_Empty & ~flush;
  assign write_Fire    = w_writeFire;
  assign read_Fire     = w_readFire;
  assign sig_Full      = (r_state == ST_FULL);
  assign sig_Empty     = (r_state == ST_EMPTY);
  assign fifo_Count    = r_count;
  assign sig_Overflow  = r_overflow;
  assign sig_Underflow = r_underflow;

  always_comb begin
    w_countNext = r_count;
    w_stateNext = r_state;
    if (flush) begin
      w_countNext = '0;
      w_stateNext = ST_EMPTY;
    end else begin
      case ({w_writeFire, w_readFire})
        2'b10:   w_countNext = r_count + CNT_ONE;
        2'b01:   w_countNext = r_count - CNT_ONE;
        default: w_countNext = r_count;
      endcase
      // A simultaneous write and read leaves the occupancy, and so the state, unchanged.
      case (r_state)
        ST_EMPTY: begin
          if (w_writeFire) w_stateNext = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (w_writeFire && !w_readFire && (r_count == CNT_LAST)) begin
            w_stateNext = ST_FULL;
          end else if (w_readFire && !w_writeFire && (r_count == CNT_ONE)) begin
            w_stateNext = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_readFire) w_stateNext = ST_PARTIAL;
        end
        default: w_stateNext = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      if (flush) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        r_overflow  <= r_overflow  | (write_Enable & sig_Full);
        r_underflow <= r_underflow | (read_Enable  & sig_Empty);
      end
    end
  end

  fifo_ptr_counter #(.WIDTH(BUFFER_WIDTH)) u_writePtr (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (flush),
    .i_enable (w_writeFire),
    .o_count  (write_Pointer)
  );

  fifo_ptr_counter #(.WIDTH(BUFFER_WIDTH)) u_readPtr (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (flush),
    .i_enable (w_readFire),
    .o_count  (read_Pointer)
  );

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [CW-1:0] AF_LEVEL = CW'(AF_THRESHOLD);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_THRESHOLD);

  logic r_almostFull;
  logic r_almostEmpty;

  // Compared against the next count so the flags line up with fifo_Count after the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
    end else begin
      r_almostFull  <= (w_countNext >= AF_LEVEL);
      r_almostEmpty <= (w_countNext <= AE_LEVEL);
    end
  end

  assign sig_Almost_Full  = r_almostFull;
  assign sig_Almost_Empty = r_almostEmpty;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a count/pointer reference model feeds an expectation queue
// that a separate monitor drains. Almost-flag checks are built when FIFO_ALMOST_FLAGS_EN is defined.
module tb_fifo_ctrl;

  localparam int BW    = 3;
  localparam int DEPTH = 1 << BW;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clock        = 1'b0;
  logic          reset        = 1'b1;
  logic          flush        = 1'b0;
  logic          write_Enable = 1'b0;
  logic          read_Enable  = 1'b0;
  logic          write_Fire;
  logic          read_Fire;
  logic [BW-1:0] write_Pointer;
  logic [BW-1:0] read_Pointer;
  logic [BW:0]   fifo_Count;
  logic          sig_Full;
  logic          sig_Empty;
  logic          sig_Overflow;
  logic          sig_Underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          sig_Almost_Full;
  logic          sig_Almost_Empty;
`endif

  typedef struct {
    bit isReset;
    bit wf;
    bit rf;
    int wptr;
    int rptr;
    int count;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  int mCount = 0;
  int mWptr  = 0;
  int mRptr  = 0;
  bit mOvf   = 1'b0;
  bit mUnf   = 1'b0;

  always #5 clock = ~clock;

  fifo_ctrl #(.BUFFER_WIDTH(BW)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .write_Enable     (write_Enable),
    .read_Enable      (read_Enable),
    .write_Fire       (write_Fire),
    .read_Fire        (read_Fire),
    .write_Pointer    (write_Pointer),
    .read_Pointer     (read_Pointer),
    .fifo_Count       (fifo_Count),
    .sig_Full         (sig_Full),
    .sig_Empty        (sig_Empty),
    .sig_Overflow     (sig_Overflow),
    .sig_Underflow    (sig_Underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .sig_Almost_Full  (sig_Almost_Full),
    .sig_Almost_Empty (sig_Almost_Empty)
`endif
  );

  task automatic checkOutput(input string name, input int got, input int expected);
    testsRun++;
    if (got != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, expected, $time);
    end
  endtask

  function automatic exp_t snapshot(input bit isReset, input bit wf, input bit rf);
    exp_t e;
    e.isReset = isReset;
    e.wf      = wf;
    e.rf      = rf;
    e.wptr    = mWptr;
    e.rptr    = mRptr;
    e.count   = mCount;
    e.ovf     = mOvf;
    e.unf     = mUnf;
    return e;
  endfunction

  task automatic clearModel();
    mCount = 0;
    mWptr  = 0;
    mRptr  = 0;
    mOvf   = 1'b0;
    mUnf   = 1'b0;
  endtask

  // Called a few ns after a rising edge; returns at the same offset after the next edge.
  task automatic applyStimulus(input bit we, input bit re, input bit fl);
    bit wf;
    bit rf;
    write_Enable = we;
    read_Enable  = re;
    flush        = fl;
    wf = we && !fl && (mCount < DEPTH);
    rf = re && !fl && (mCount > 0);
    if (fl) begin
      clearModel();
    end else begin
      if (we && (mCount == DEPTH)) mOvf = 1'b1;
      if (re && (mCount == 0))     mUnf = 1'b1;
      if (wf) mWptr = (mWptr + 1) % DEPTH;
      if (rf) mRptr = (mRptr + 1) % DEPTH;
      mCount = mCount + (wf ? 1 : 0) - (rf ? 1 : 0);
    end
    expQ.push_back(snapshot(1'b0, wf, rf));
    @(posedge clock);
    #3;
  endtask

  task automatic pulseReset();
    write_Enable = 1'b0;
    read_Enable  = 1'b0;
    flush        = 1'b0;
    reset        = 1'b1;
    clearModel();
    expQ.push_back(snapshot(1'b1, 1'b0, 1'b0));
    @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  task automatic checkState(input exp_t e);
    checkOutput("write_Pointer", int'(write_Pointer), e.wptr);
    checkOutput("read_Pointer",  int'(read_Pointer),  e.rptr);
    checkOutput("fifo_Count",    int'(fifo_Count),    e.count);
    checkOutput("sig_Full",      int'(sig_Full),      (e.count == DEPTH) ? 1 : 0);
    checkOutput("sig_Empty",     int'(sig_Empty),     (e.count == 0) ? 1 : 0);
    checkOutput("sig_Overflow",  int'(sig_Overflow),  int'(e.ovf));
    checkOutput("sig_Underflow", int'(sig_Underflow), int'(e.unf));
`ifdef FIFO_ALMOST_FLAGS_EN
    checkOutput("sig_Almost_Full",  int'(sig_Almost_Full),  (e.count >= AF) ? 1 : 0);
    checkOutput("sig_Almost_Empty", int'(sig_Almost_Empty), (e.count <= AE) ? 1 : 0);
`endif
  endtask

  // Fires are judged mid-cycle with inputs settled; state is judged just after the consuming edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if (e.isReset) begin
          checkState(e);
        end else begin
          checkOutput("write_Fire", int'(write_Fire), int'(e.wf));
          checkOutput("read_Fire",  int'(read_Fire),  int'(e.rf));
          @(posedge clock);
          #1;
          checkState(e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int r;
    int wProb;
    @(posedge clock);
    #3;
    pulseReset();

    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);

    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    pulseReset();

    // Phases biased toward filling, balanced and draining so every state is visited.
    for (int phase = 0; phase < 4; phase++) begin
      case (phase)
        0:       wProb = 80;
        1:       wProb = 50;
        2:       wProb = 20;
        default: wProb = 55;
      endcase
      for (int i = 0; i < 100; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 2) begin
          pulseReset();
        end else begin
          applyStimulus(int'($urandom_range(0, 99)) < wProb,
                        int'($urandom_range(0, 99)) < (100 - wProb),
                        int'($urandom_range(0, 99)) < 3);
        end
      end
    end

    repeat (2) @(posedge clock);
    #3;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
